// File: rtl/demux14_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux14_stream
// Brief    : Registered 1-to-4 stream demultiplexer. One input word per cycle
//            is routed to channel {s1,s0}; each channel has a one-entry
//            holding register with its own valid/ready handshake and an
//            accept counter for bring-up.
// Revision : 1.0 - initial release
// ============================================================================
module demux14_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 s0,
    input  logic                 s1,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [4*CNT_W-1:0]   xfer_cnt
);

    // Per-channel holding register state
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic [1:0]       w_sel;
    logic             w_accept;
    logic [3:0]       w_acc;
    logic [3:0]       w_drain;
    logic [3:0]       r_state;
    logic [3:0]       w_state_nxt;
    logic [WIDTH-1:0] r_data [4];
    logic [CNT_W-1:0] r_cnt  [4];

    // s1 picks the pair, s0 picks within the pair, matching the 4:1 mux
    assign w_sel = {s1, s0};

    // Only the selected channel can stall the producer; no register here so
    // a channel draining this cycle can be refilled in the same cycle.
    assign in_ready = (r_state[w_sel] == ST_EMPTY) | out_ready[w_sel];
    assign w_accept = in_valid & in_ready;

    // Decode accept and drain events per channel
    always_comb begin
        w_acc = 4'b0000;
        if (w_accept) begin
            w_acc[w_sel] = 1'b1;
        end
        w_drain = r_state & out_ready;
    end

    // Next-state logic for the four EMPTY/FULL channel machines
    always_comb begin
        w_state_nxt = r_state;
        for (int k = 0; k < 4; k++) begin
            case (r_state[k])
                ST_EMPTY: if (w_acc[k]) w_state_nxt[k] = ST_FULL;
                ST_FULL:  if (w_drain[k] && !w_acc[k]) w_state_nxt[k] = ST_EMPTY;
                default:  w_state_nxt[k] = ST_EMPTY;
            endcase
        end
    end

    // Channel state register; a held word is dropped on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= {4{ST_EMPTY}};
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holding data and accept counters; counters wrap silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_data[k] <= '0;
                r_cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_acc[k]) begin
                    r_data[k] <= in_data;
                    r_cnt[k]  <= r_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // Flatten per-channel registers onto the output buses
    always_comb begin
        out_valid = r_state;
        out_data  = '0;
        xfer_cnt  = '0;
        for (int k = 0; k < 4; k++) begin
            out_data[k*WIDTH +: WIDTH] = r_data[k];
            xfer_cnt[k*CNT_W +: CNT_W] = r_cnt[k];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_demux14_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux14_stream
// Brief    : Directed self-checking bench for demux14_stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux14_stream;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 s0;
    logic                 s1;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic [4*WIDTH-1:0]   out_data;
    logic [4*CNT_W-1:0]   xfer_cnt;

    int n_checks;
    int n_pass;

    demux14_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .s0        (s0),
        .s1        (s1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .xfer_cnt  (xfer_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] chan_data(input int k);
        return 32'(out_data[k*WIDTH +: WIDTH]);
    endfunction

    function automatic logic [31:0] chan_cnt(input int k);
        return 32'(xfer_cnt[k*CNT_W +: CNT_W]);
    endfunction

    // Present a word on the input (inputs settle before the next edge)
    task automatic drive(input logic [1:0] ch, input logic [7:0] d);
        in_valid = 1'b1;
        s1       = ch[1];
        s0       = ch[0];
        in_data  = d;
        #1;
    endtask

    // Advance one clock and sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        s0        = 1'b0;
        s1        = 1'b0;
        out_ready = 4'b0000;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // ---- Reset: load channel 2 with 0xA5 then assert reset mid-cycle
        drive(2'd2, 8'hA5);
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'h4);
        check("pre_rst_data2", chan_data(2), 32'hA5);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", out_data, 32'h0);
        check("rst_cnt", xfer_cnt, 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        tick();
        rst_n = 1'b1;
        tick();

        // ---- Routing sweep on consecutive cycles
        out_ready = 4'b1111;
        drive(2'd0, 8'h11); tick();
        check("sweep0_valid", 32'(out_valid), 32'h1);
        check("sweep0_data", chan_data(0), 32'h11);
        drive(2'd1, 8'h22); tick();
        check("sweep1_valid", 32'(out_valid), 32'h2);
        check("sweep1_data", chan_data(1), 32'h22);
        drive(2'd2, 8'h44); tick();
        check("sweep2_valid", 32'(out_valid), 32'h4);
        check("sweep2_data", chan_data(2), 32'h44);
        drive(2'd3, 8'h88); tick();
        check("sweep3_valid", 32'(out_valid), 32'h8);
        check("sweep3_data", chan_data(3), 32'h88);
        in_valid = 1'b0;
        tick();
        check("sweep_drained", 32'(out_valid), 32'h0);
        check("sweep_cnt", xfer_cnt, 32'h01010101);

        // ---- Backpressure on channel 3
        out_ready = 4'b0111;
        drive(2'd3, 8'h5A); tick();
        check("bp_first_valid", 32'(out_valid), 32'h8);
        drive(2'd3, 8'h6B);
        check("bp_in_ready_low", 32'(in_ready), 32'h0);
        tick();
        check("bp_hold_data", chan_data(3), 32'h5A);
        check("bp_hold_valid", 32'(out_valid[3]), 32'h1);
        check("bp_hold_cnt3", chan_cnt(3), 32'h2);
        out_ready = 4'b1111;
        #1;
        check("bp_in_ready_high", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check("bp_replace_valid", 32'(out_valid[3]), 32'h1);
        check("bp_replace_data", chan_data(3), 32'h6B);
        check("bp_replace_cnt3", chan_cnt(3), 32'h3);
        tick();
        check("bp_drained", 32'(out_valid), 32'h0);

        // ---- Independence: channel 1 stalled, traffic to channel 0
        out_ready = 4'b1101;
        drive(2'd1, 8'h77); tick();
        drive(2'd0, 8'h3C);
        check("ind_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check("ind_valid", 32'(out_valid), 32'h3);
        check("ind_data0", chan_data(0), 32'h3C);
        check("ind_data1", chan_data(1), 32'h77);
        out_ready = 4'b1111;
        tick();
        check("ind_drained", 32'(out_valid), 32'h0);

        // ---- Full throughput into channel 2
        for (int i = 0; i < 10; i++) begin
            drive(2'd2, 8'(i));
            check($sformatf("tp_in_ready_%0d", i), 32'(in_ready), 32'h1);
            tick();
            check($sformatf("tp_valid_%0d", i), 32'(out_valid[2]), 32'h1);
            check($sformatf("tp_data_%0d", i), chan_data(2), 32'(i));
        end
        in_valid = 1'b0;
        tick();
        check("tp_drained", 32'(out_valid), 32'h0);
        check("all_cnt", xfer_cnt, 32'h030B0202);

        // ---- Counter wrap on channel 0 from a fresh reset
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 255; i++) begin
            drive(2'd0, 8'(i));
            tick();
        end
        check("wrap_cnt0_255", chan_cnt(0), 32'd255);
        check("wrap_others_255", 32'(xfer_cnt[4*CNT_W-1:CNT_W]), 32'h0);
        drive(2'd0, 8'hFF);
        tick();
        in_valid = 1'b0;
        check("wrap_cnt0_0", chan_cnt(0), 32'd0);
        check("wrap_others_0", 32'(xfer_cnt[4*CNT_W-1:CNT_W]), 32'h0);
        check("wrap_last_data", chan_data(0), 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
